// File: rtl/adam_mem_prof_pkg.sv
// Shared types for the memory-traffic profiler: FSM state encoding and
// readout counter-select codes.
package adam_mem_prof_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_FROZEN = 2'd3
    } prof_state_e;

    typedef enum logic [1:0] {
        SEL_RD_OPS   = 2'd0,
        SEL_WR_OPS   = 2'd1,
        SEL_RD_BYTES = 2'd2,
        SEL_WR_BYTES = 2'd3
    } rd_sel_e;

endpackage

// File: rtl/adam_mem_prof_chan.sv
// Purpose: per-port read/write op and byte counters (ADAM_MEM_PROF_SAT_EN selects saturate vs wrap).
// Latency: counters update on the clock edge closing a counted cycle.
// Backpressure: none; passive monitor, never stalls the observed port.
module adam_mem_prof_chan #(
    parameter int STRB_WIDTH = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cnt_en,
    input  logic                  clr,
    input  logic                  req,
    input  logic                  we,
    input  logic [STRB_WIDTH-1:0] be,
    output logic [CNT_WIDTH-1:0]  rd_ops,
    output logic [CNT_WIDTH-1:0]  wr_ops,
    output logic [CNT_WIDTH-1:0]  rd_bytes,
    output logic [CNT_WIDTH-1:0]  wr_bytes,
    output logic                  overflow
);

    // Returns {overflowed, result}; in wrap builds the top bit is always 0.
    function automatic logic [CNT_WIDTH:0] acc(input logic [CNT_WIDTH-1:0] a,
                                               input logic [CNT_WIDTH-1:0] b);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef ADAM_MEM_PROF_SAT_EN
        if (s[CNT_WIDTH]) begin
            s = {1'b1, {CNT_WIDTH{1'b1}}};
        end
`else
        s[CNT_WIDTH] = 1'b0;
`endif
        return s;
    endfunction

    logic                 rd_hit;
    logic                 wr_hit;
    logic                 ovf_hit;
    logic [CNT_WIDTH-1:0] be_cnt;
    logic [CNT_WIDTH:0]   rd_ops_n;
    logic [CNT_WIDTH:0]   wr_ops_n;
    logic [CNT_WIDTH:0]   rd_bytes_n;
    logic [CNT_WIDTH:0]   wr_bytes_n;

    assign rd_hit = cnt_en & req & ~we;
    assign wr_hit = cnt_en & req & we;

    always_comb begin
        be_cnt = '0;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            be_cnt = be_cnt + CNT_WIDTH'(be[i]);
        end
    end

    always_comb begin
        rd_ops_n   = acc(rd_ops, CNT_WIDTH'(1));
        wr_ops_n   = acc(wr_ops, CNT_WIDTH'(1));
        rd_bytes_n = acc(rd_bytes, CNT_WIDTH'(STRB_WIDTH));
        wr_bytes_n = acc(wr_bytes, be_cnt);
        ovf_hit    = (rd_hit & (rd_ops_n[CNT_WIDTH] | rd_bytes_n[CNT_WIDTH])) |
                     (wr_hit & (wr_ops_n[CNT_WIDTH] | wr_bytes_n[CNT_WIDTH]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ops   <= '0;
            wr_ops   <= '0;
            rd_bytes <= '0;
            wr_bytes <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            rd_ops   <= '0;
            wr_ops   <= '0;
            rd_bytes <= '0;
            wr_bytes <= '0;
            overflow <= 1'b0;
        end else begin
            if (rd_hit) begin
                rd_ops   <= rd_ops_n[CNT_WIDTH-1:0];
                rd_bytes <= rd_bytes_n[CNT_WIDTH-1:0];
            end
            if (wr_hit) begin
                wr_ops   <= wr_ops_n[CNT_WIDTH-1:0];
                wr_bytes <= wr_bytes_n[CNT_WIDTH-1:0];
            end
            if (ovf_hit) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/adam_mem_prof.sv
// Purpose: multi-port memory traffic profiler with warm-up/run/freeze FSM (ADAM_MEM_PROF_SAT_EN: saturating counters).
// Latency: rd_data/rd_valid one cycle after rd_req; counters reflect a RUN cycle one edge later.
// Backpressure: none; readout always accepted, monitored ports are never stalled.
module adam_mem_prof
    import adam_mem_prof_pkg::*;
#(
    parameter int NO_CHANNELS   = 2,
    parameter int STRB_WIDTH    = 4,
    parameter int CNT_WIDTH     = 32,
    parameter int WARMUP_CYCLES = 100000,
    localparam int CH_W = (NO_CHANNELS > 1) ? $clog2(NO_CHANNELS) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              stop,
    input  logic                              clear,
    input  logic [NO_CHANNELS-1:0]            mon_req,
    input  logic [NO_CHANNELS-1:0]            mon_we,
    input  logic [NO_CHANNELS*STRB_WIDTH-1:0] mon_be,
    input  logic                              rd_req,
    input  logic [CH_W-1:0]                   rd_ch,
    input  logic [1:0]                        rd_sel,
    output logic [CNT_WIDTH-1:0]              rd_data,
    output logic                              rd_valid,
    output logic [1:0]                        state,
    output logic [CNT_WIDTH-1:0]              run_cycles,
    output logic [NO_CHANNELS-1:0]            overflow
);

    localparam int WU_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam logic [WU_W-1:0] WU_LAST = (WARMUP_CYCLES > 0) ? WU_W'(WARMUP_CYCLES - 1) : '0;

    prof_state_e          state_q;
    prof_state_e          state_d;
    logic [WU_W-1:0]      wu_cnt;
    logic                 cnt_en;
    logic [CNT_WIDTH-1:0] rd_mux;

    logic [CNT_WIDTH-1:0] ch_rd_ops   [NO_CHANNELS];
    logic [CNT_WIDTH-1:0] ch_wr_ops   [NO_CHANNELS];
    logic [CNT_WIDTH-1:0] ch_rd_bytes [NO_CHANNELS];
    logic [CNT_WIDTH-1:0] ch_wr_bytes [NO_CHANNELS];

    // Priority clear > stop > start; illegal-state requests simply hold.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = (WARMUP_CYCLES == 0) ? ST_RUN : ST_WARMUP;
                    end
                end
                ST_WARMUP: begin
                    if (stop) begin
                        state_d = ST_FROZEN;
                    end else if (wu_cnt == WU_LAST) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_d = ST_FROZEN;
                    end
                end
                ST_FROZEN: begin
                    if (start) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wu_cnt <= '0;
        end else if (state_q == ST_WARMUP && state_d == ST_WARMUP) begin
            wu_cnt <= wu_cnt + WU_W'(1);
        end else begin
            wu_cnt <= '0;
        end
    end

    assign state  = state_q;
    assign cnt_en = (state_q == ST_RUN) && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cycles <= '0;
        end else if (clear) begin
            run_cycles <= '0;
        end else if (state_q == ST_RUN) begin
`ifdef ADAM_MEM_PROF_SAT_EN
            if (run_cycles != '1) begin
                run_cycles <= run_cycles + CNT_WIDTH'(1);
            end
`else
            run_cycles <= run_cycles + CNT_WIDTH'(1);
`endif
        end
    end

    for (genvar g = 0; g < NO_CHANNELS; g++) begin : g_chan
        adam_mem_prof_chan #(
            .STRB_WIDTH (STRB_WIDTH),
            .CNT_WIDTH  (CNT_WIDTH)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .cnt_en   (cnt_en),
            .clr      (clear),
            .req      (mon_req[g]),
            .we       (mon_we[g]),
            .be       (mon_be[g*STRB_WIDTH +: STRB_WIDTH]),
            .rd_ops   (ch_rd_ops[g]),
            .wr_ops   (ch_wr_ops[g]),
            .rd_bytes (ch_rd_bytes[g]),
            .wr_bytes (ch_wr_bytes[g]),
            .overflow (overflow[g])
        );
    end

    // Out-of-range channels match no loop iteration and read back as zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NO_CHANNELS; i++) begin
            if (int'(rd_ch) == i) begin
                case (rd_sel)
                    SEL_RD_OPS:   rd_mux = ch_rd_ops[i];
                    SEL_WR_OPS:   rd_mux = ch_wr_ops[i];
                    SEL_RD_BYTES: rd_mux = ch_rd_bytes[i];
                    default:      rd_mux = ch_wr_bytes[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_data <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_adam_mem_prof.sv
// Directed bench for adam_mem_prof: 3 channels, 4-byte strobes, 8-bit counters, 10-cycle warm-up.
module tb_adam_mem_prof;

    localparam int NCH = 3;
    localparam int SW  = 4;
    localparam int CW  = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic            clear = 1'b0;
    logic [NCH-1:0]  mon_req = '0;
    logic [NCH-1:0]  mon_we = '0;
    logic [NCH*SW-1:0] mon_be = '0;
    logic            rd_req = 1'b0;
    logic [1:0]      rd_ch = '0;
    logic [1:0]      rd_sel = '0;
    logic [CW-1:0]   rd_data;
    logic            rd_valid;
    logic [1:0]      state;
    logic [CW-1:0]   run_cycles;
    logic [NCH-1:0]  overflow;

    int checks = 0;
    int errors = 0;

    adam_mem_prof #(
        .NO_CHANNELS   (NCH),
        .STRB_WIDTH    (SW),
        .CNT_WIDTH     (CW),
        .WARMUP_CYCLES (10)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
        .mon_req    (mon_req),
        .mon_we     (mon_we),
        .mon_be     (mon_be),
        .rd_req     (rd_req),
        .rd_ch      (rd_ch),
        .rd_sel     (rd_sel),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .state      (state),
        .run_cycles (run_cycles),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input int ch, input int sel, output logic [CW-1:0] d, output logic v);
        rd_req = 1'b1;
        rd_ch  = 2'(ch);
        rd_sel = 2'(sel);
        tick();
        d = rd_data;
        v = rd_valid;
        rd_req = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        checks++; if (rd_data !== 8'd0) begin errors++; $display("FAIL reset_rd_data: got %0d want 0", rd_data); end
        checks++; if (run_cycles !== 8'd0) begin errors++; $display("FAIL reset_run_cycles: got %0d want 0", run_cycles); end
        checks++; if (overflow !== 3'b000) begin errors++; $display("FAIL reset_overflow: got %b want 000", overflow); end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL idle_after_reset: got %0d want 0", state); end
    endtask

    task automatic test_warmup();
        logic [CW-1:0] d;
        logic v;
        start = 1'b1;
        mon_req = 3'b001;
        tick();
        start = 1'b0;
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL warmup_enter: got %0d want 1", state); end
        repeat (9) tick();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL warmup_hold10: got %0d want 1", state); end
        tick();
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL run_at_11: got %0d want 2", state); end
        checks++; if (run_cycles !== 8'd0) begin errors++; $display("FAIL run_cycles_warm: got %0d want 0", run_cycles); end
        tick();
        mon_req = '0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL frozen_after_stop: got %0d want 3", state); end
        do_read(0, 0, d, v);
        checks++; if (d !== 8'd1 || v !== 1'b1) begin errors++; $display("FAIL warm_rd_ops: got %0d/%b want 1/1", d, v); end
        do_read(0, 2, d, v);
        checks++; if (d !== 8'd4) begin errors++; $display("FAIL warm_rd_bytes: got %0d want 4", d); end
        checks++; if (run_cycles !== 8'd2) begin errors++; $display("FAIL warm_run_cycles: got %0d want 2", run_cycles); end
    endtask

    task automatic test_writes();
        logic [CW-1:0] d;
        logic v;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL resume_no_warmup: got %0d want 2", state); end
        mon_req = 3'b011;
        mon_we  = 3'b010;
        mon_be  = 12'h0B0;
        repeat (3) tick();
        mon_be = 12'h000;
        tick();
        mon_req = 3'b001;
        mon_we  = 3'b000;
        tick();
        mon_req = '0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        do_read(1, 1, d, v);
        checks++; if (d !== 8'd4) begin errors++; $display("FAIL ch1_wr_ops: got %0d want 4", d); end
        do_read(1, 3, d, v);
        checks++; if (d !== 8'd9) begin errors++; $display("FAIL ch1_wr_bytes: got %0d want 9", d); end
        do_read(1, 0, d, v);
        checks++; if (d !== 8'd0) begin errors++; $display("FAIL ch1_rd_ops: got %0d want 0", d); end
        // ch0 already holds one read from the warm-up test
        do_read(0, 0, d, v);
        checks++; if (d !== 8'd6) begin errors++; $display("FAIL ch0_rd_ops: got %0d want 6", d); end
        do_read(0, 2, d, v);
        checks++; if (d !== 8'd24) begin errors++; $display("FAIL ch0_rd_bytes: got %0d want 24", d); end
        do_read(2, 3, d, v);
        checks++; if (d !== 8'd0) begin errors++; $display("FAIL ch2_wr_bytes: got %0d want 0", d); end
        do_read(3, 0, d, v);
        checks++; if (d !== 8'd0 || v !== 1'b1) begin errors++; $display("FAIL bad_channel: got %0d/%b want 0/1", d, v); end
        checks++; if (run_cycles !== 8'd8) begin errors++; $display("FAIL writes_run_cycles: got %0d want 8", run_cycles); end
    endtask

    task automatic test_stop_concurrent();
        logic [CW-1:0] d;
        logic v;
        start = 1'b1;
        tick();
        start = 1'b0;
        mon_req = 3'b100;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL stop_state: got %0d want 3", state); end
        tick();
        mon_req = '0;
        do_read(2, 0, d, v);
        checks++; if (d !== 8'd1) begin errors++; $display("FAIL stop_cycle_read: got %0d want 1", d); end
        do_read(2, 2, d, v);
        checks++; if (d !== 8'd4) begin errors++; $display("FAIL stop_cycle_bytes: got %0d want 4", d); end
        checks++; if (run_cycles !== 8'd9) begin errors++; $display("FAIL stop_run_cycles: got %0d want 9", run_cycles); end
    endtask

    task automatic test_read_timing();
        logic [CW-1:0] d;
        logic v;
        start = 1'b1;
        tick();
        start = 1'b0;
        mon_req = 3'b001;
        rd_req = 1'b1;
        rd_ch = 2'd0;
        rd_sel = 2'd0;
        tick();
        checks++; if (rd_data !== 8'd6 || rd_valid !== 1'b1) begin errors++; $display("FAIL read_before_update: got %0d/%b want 6/1", rd_data, rd_valid); end
        rd_req = 1'b0;
        mon_req = '0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++; if (rd_valid !== 1'b0 || rd_data !== 8'd6) begin errors++; $display("FAIL rd_hold: got %0d/%b want 6/0", rd_data, rd_valid); end
        do_read(0, 0, d, v);
        checks++; if (d !== 8'd7) begin errors++; $display("FAIL read_after_update: got %0d want 7", d); end
        checks++; if (run_cycles !== 8'd11) begin errors++; $display("FAIL timing_run_cycles: got %0d want 11", run_cycles); end
    endtask

    task automatic test_clear_priority();
        logic [CW-1:0] d;
        logic v;
        start = 1'b1;
        tick();
        mon_req = 3'b111;
        clear = 1'b1;
        stop = 1'b1;
        tick();
        clear = 1'b0;
        stop = 1'b0;
        start = 1'b0;
        mon_req = '0;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL clear_state: got %0d want 0", state); end
        checks++; if (run_cycles !== 8'd0) begin errors++; $display("FAIL clear_run_cycles: got %0d want 0", run_cycles); end
        do_read(0, 0, d, v);
        checks++; if (d !== 8'd0) begin errors++; $display("FAIL clear_ch0_rd_ops: got %0d want 0", d); end
        do_read(1, 3, d, v);
        checks++; if (d !== 8'd0) begin errors++; $display("FAIL clear_ch1_wr_bytes: got %0d want 0", d); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL clear_stays_idle: got %0d want 0", state); end
    endtask

    task automatic test_wrap();
        logic [CW-1:0] d;
        logic v;
        logic [CW-1:0] exp_bytes;
        logic [NCH-1:0] exp_ovf;
`ifdef ADAM_MEM_PROF_SAT_EN
        exp_bytes = 8'd255;
        exp_ovf = 3'b001;
`else
        exp_bytes = 8'd24;
        exp_ovf = 3'b000;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20 && state !== 2'd2; i++) tick();
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL wrap_reach_run: got %0d want 2", state); end
        mon_req = 3'b001;
        mon_we  = 3'b001;
        mon_be  = 12'h00F;
        repeat (70) tick();
        mon_req = '0;
        mon_we = '0;
        mon_be = '0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        do_read(0, 3, d, v);
        checks++; if (d !== exp_bytes) begin errors++; $display("FAIL wrap_wr_bytes: got %0d want %0d", d, exp_bytes); end
        do_read(0, 1, d, v);
        checks++; if (d !== 8'd70) begin errors++; $display("FAIL wrap_wr_ops: got %0d want 70", d); end
        checks++; if (overflow !== exp_ovf) begin errors++; $display("FAIL wrap_overflow: got %b want %b", overflow, exp_ovf); end
    endtask

    task automatic test_reset_mid_run();
        logic [CW-1:0] d;
        logic v;
        start = 1'b1;
        tick();
        start = 1'b0;
        mon_req = 3'b001;
        rd_req = 1'b1;
        rd_ch = 2'd0;
        rd_sel = 2'd3;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL arst_state: got %0d want 0", state); end
        checks++; if (rd_data !== 8'd0) begin errors++; $display("FAIL arst_rd_data: got %0d want 0", rd_data); end
        checks++; if (run_cycles !== 8'd0) begin errors++; $display("FAIL arst_run_cycles: got %0d want 0", run_cycles); end
        checks++; if (overflow !== 3'b000) begin errors++; $display("FAIL arst_overflow: got %b want 000", overflow); end
        tick();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL arst_rd_valid: got %b want 0", rd_valid); end
        rd_req = 1'b0;
        mon_req = '0;
        rst_n = 1'b1;
        tick();
        checks++; if (rd_valid !== 1'b0 || state !== 2'd0) begin errors++; $display("FAIL post_reset: got %b/%0d want 0/0", rd_valid, state); end
        do_read(0, 3, d, v);
        checks++; if (d !== 8'd0) begin errors++; $display("FAIL arst_counts_gone: got %0d want 0", d); end
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_writes();
        test_stop_concurrent();
        test_read_timing();
        test_clear_priority();
        test_wrap();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
